// File: rtl/upcount_ctrl.sv
// Sequencing controller for the 4-bit up counter datapath: loads a start value,
// counts to a terminal value at a prescaled rate, and reports busy/done/wrap.
module upcount_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    input  logic             auto_reload,
    input  logic             step_en,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [7:0]       PS_MAX = 8'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL1   = '1;

    state_t           state;
    logic [7:0]       prescaler;
    logic [WIDTH-1:0] load_r;
    logic [WIDTH-1:0] term_r;
    logic             rl_r;
    logic             tick;

    assign tick = step_en && (prescaler == PS_MAX);

    // done and wrap default low every cycle so each is a single-cycle pulse;
    // stop is checked before the tick so it overrides terminal and wrap events.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            prescaler <= '0;
            load_r    <= '0;
            term_r    <= '0;
            rl_r      <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        load_r <= load_val;
                        term_r <= term_val;
                        rl_r   <= auto_reload;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        count_out <= load_r;
                        prescaler <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (tick) begin
                        prescaler <= '0;
                        if (count_out == term_r) begin
                            done <= 1'b1;
                            if (rl_r) begin
                                count_out <= load_r;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            count_out <= count_out + ONE;
                            wrap      <= (count_out == ALL1);
                        end
                    end else if (step_en) begin
                        prescaler <= prescaler + 8'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upcount_ctrl.sv
// Scoreboard bench for upcount_ctrl: one instance with PRESCALE=1, one with
// PRESCALE=3; the instance not under test is held in reset.
module tb_upcount_ctrl;

    typedef struct {
        bit         sel3;
        logic [3:0] cnt;
        logic       busy;
        logic       done;
        logic       wrap;
        string      tag;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       reset1, reset3;
    logic       start, stop, auto_reload, step_en;
    logic [3:0] load_val, term_val;
    logic [3:0] count1, count3;
    logic       busy1, busy3, done1, done3, wrap1, wrap3;

    int errors = 0;
    int checks = 0;
    sb_entry_t sb[$];
    sb_entry_t e;

    upcount_ctrl #(.WIDTH(4), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset1), .start(start), .stop(stop),
        .load_val(load_val), .term_val(term_val), .auto_reload(auto_reload),
        .step_en(step_en), .count_out(count1), .busy(busy1), .done(done1), .wrap(wrap1)
    );

    upcount_ctrl #(.WIDTH(4), .PRESCALE(3)) dut3 (
        .clk(clk), .reset(reset3), .start(start), .stop(stop),
        .load_val(load_val), .term_val(term_val), .auto_reload(auto_reload),
        .step_en(step_en), .count_out(count3), .busy(busy3), .done(done3), .wrap(wrap3)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs and records what must be visible after the next edge.
    task automatic applyStimulus(input bit sel3, input logic rst, input logic st, input logic sp,
                                 input logic se, input logic [3:0] ecnt, input logic ebusy,
                                 input logic edone, input logic ewrap, input string tag);
        sb_entry_t n;
        @(negedge clk);
        reset1  = sel3 ? 1'b1 : rst;
        reset3  = sel3 ? rst : 1'b1;
        start   = st;
        stop    = sp;
        step_en = se;
        n.sel3 = sel3; n.cnt = ecnt; n.busy = ebusy; n.done = edone; n.wrap = ewrap; n.tag = tag;
        sb.push_back(n);
    endtask

    always @(posedge clk) begin
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({e.tag, ".count"}, e.sel3 ? 32'(count3) : 32'(count1), 32'(e.cnt));
            checkOutput({e.tag, ".busy"},  e.sel3 ? 32'(busy3)  : 32'(busy1),  32'(e.busy));
            checkOutput({e.tag, ".done"},  e.sel3 ? 32'(done3)  : 32'(done1),  32'(e.done));
            checkOutput({e.tag, ".wrap"},  e.sel3 ? 32'(wrap3)  : 32'(wrap1),  32'(e.wrap));
        end
    end

    // PRESCALE=3 run from load=0 to term=2 with step_en low on edges gap_lo..gap_hi.
    task automatic runPrescaleCase(input int gap_lo, input int gap_hi, input logic [3:0] prev, input string tag);
        int enabled = 0;
        int ticks;
        logic en;
        load_val = 4'd0; term_val = 4'd2; auto_reload = 1'b0;
        applyStimulus(1, 0, 1, 0, 1, prev, 1, 0, 0, {tag, ".e0"});
        applyStimulus(1, 0, 0, 0, 1, 4'd0, 1, 0, 0, {tag, ".e1"});
        for (int edge_i = 2; edge_i < 40; edge_i++) begin
            en = !(edge_i >= gap_lo && edge_i <= gap_hi);
            if (en) enabled++;
            ticks = enabled / 3;
            if (ticks >= 3) begin
                applyStimulus(1, 0, 0, 0, en, 4'd2, 0, 1, 0, $sformatf("%s.done_e%0d", tag, edge_i));
                break;
            end
            applyStimulus(1, 0, 0, 0, en, 4'(ticks), 1, 0, 0, $sformatf("%s.e%0d", tag, edge_i));
        end
        applyStimulus(1, 0, 0, 0, 1, 4'd2, 0, 0, 0, {tag, ".after"});
    endtask

    initial begin
        reset1 = 1'b1; reset3 = 1'b1; start = 1'b0; stop = 1'b0;
        auto_reload = 1'b0; step_en = 1'b1; load_val = 4'd0; term_val = 4'd0;

        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0, 1, 4'd0, 0, 0, 0, "reset");
        for (int i = 0; i < 5; i++)  applyStimulus(0, 0, 0, 1, 1, 4'd0, 0, 0, 0, "idle");

        // One-shot 3..7
        load_val = 4'd3; term_val = 4'd7; auto_reload = 1'b0;
        applyStimulus(0, 0, 1, 0, 1, 4'd0, 1, 0, 0, "os.e0");
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1, 4'(3 + i), 1, 0, 0, $sformatf("os.e%0d", i + 1));
        applyStimulus(0, 0, 0, 0, 1, 4'd7, 0, 1, 0, "os.done");
        applyStimulus(0, 0, 0, 0, 1, 4'd7, 0, 0, 0, "os.hold");

        // Wrap path 14,15,0,1
        load_val = 4'd14; term_val = 4'd1;
        applyStimulus(0, 0, 1, 0, 1, 4'd7,  1, 0, 0, "wr.e0");
        applyStimulus(0, 0, 0, 0, 1, 4'd14, 1, 0, 0, "wr.e1");
        applyStimulus(0, 0, 0, 0, 1, 4'd15, 1, 0, 0, "wr.e2");
        applyStimulus(0, 0, 0, 0, 1, 4'd0,  1, 0, 1, "wr.e3");
        applyStimulus(0, 0, 0, 0, 1, 4'd1,  1, 0, 0, "wr.e4");
        applyStimulus(0, 0, 0, 0, 1, 4'd1,  0, 1, 0, "wr.done");
        applyStimulus(0, 0, 0, 0, 1, 4'd1,  0, 0, 0, "wr.hold");

        // Auto-reload 2..4 with an ignored start mid-run, then stop at 3
        load_val = 4'd2; term_val = 4'd4; auto_reload = 1'b1;
        applyStimulus(0, 0, 1, 0, 1, 4'd1, 1, 0, 0, "ar.e0");
        applyStimulus(0, 0, 0, 0, 1, 4'd2, 1, 0, 0, "ar.e1");
        applyStimulus(0, 0, 0, 0, 1, 4'd3, 1, 0, 0, "ar.e2");
        applyStimulus(0, 0, 0, 0, 1, 4'd4, 1, 0, 0, "ar.e3");
        applyStimulus(0, 0, 0, 0, 1, 4'd2, 1, 1, 0, "ar.e4");
        load_val = 4'd9; term_val = 4'd11; auto_reload = 1'b0;
        applyStimulus(0, 0, 1, 0, 1, 4'd3, 1, 0, 0, "ar.e5");
        applyStimulus(0, 0, 0, 0, 1, 4'd4, 1, 0, 0, "ar.e6");
        applyStimulus(0, 0, 0, 0, 1, 4'd2, 1, 1, 0, "ar.e7");
        applyStimulus(0, 0, 0, 0, 1, 4'd3, 1, 0, 0, "ar.e8");
        applyStimulus(0, 0, 0, 1, 1, 4'd3, 0, 0, 0, "ar.stop");
        applyStimulus(0, 0, 0, 0, 1, 4'd3, 0, 0, 0, "ar.idle");

        // Stop coinciding with the terminal tick
        load_val = 4'd5; term_val = 4'd6; auto_reload = 1'b0;
        applyStimulus(0, 0, 1, 0, 1, 4'd3, 1, 0, 0, "st.e0");
        applyStimulus(0, 0, 0, 0, 1, 4'd5, 1, 0, 0, "st.e1");
        applyStimulus(0, 0, 0, 0, 1, 4'd6, 1, 0, 0, "st.e2");
        applyStimulus(0, 0, 0, 1, 1, 4'd6, 0, 0, 0, "st.term");
        applyStimulus(0, 0, 0, 0, 1, 4'd6, 0, 0, 0, "st.idle");

        // load == term terminates on the first tick
        load_val = 4'd8; term_val = 4'd8;
        applyStimulus(0, 0, 1, 0, 1, 4'd6, 1, 0, 0, "eq.e0");
        applyStimulus(0, 0, 0, 0, 1, 4'd8, 1, 0, 0, "eq.e1");
        applyStimulus(0, 0, 0, 0, 1, 4'd8, 0, 1, 0, "eq.e2");
        applyStimulus(0, 0, 0, 0, 1, 4'd8, 0, 0, 0, "eq.e3");

        // Stop during LOAD skips the load
        load_val = 4'd12; term_val = 4'd13;
        applyStimulus(0, 0, 1, 0, 1, 4'd8, 1, 0, 0, "sl.e0");
        applyStimulus(0, 0, 0, 1, 1, 4'd8, 0, 0, 0, "sl.e1");
        applyStimulus(0, 0, 0, 0, 1, 4'd8, 0, 0, 0, "sl.e2");

        // Reset mid-run
        load_val = 4'd0; term_val = 4'd15;
        applyStimulus(0, 0, 1, 0, 1, 4'd8, 1, 0, 0, "rm.e0");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 1, 0, 0, "rm.e1");
        applyStimulus(0, 0, 0, 0, 1, 4'd1, 1, 0, 0, "rm.e2");
        applyStimulus(0, 0, 0, 0, 1, 4'd2, 1, 0, 0, "rm.e3");
        applyStimulus(0, 1, 0, 0, 1, 4'd0, 0, 0, 0, "rm.reset");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 0, 0, 0, "rm.idle");

        // PRESCALE=3: no gap (done at E10), then a 4-cycle step_en gap (done at E14)
        applyStimulus(1, 1, 0, 0, 1, 4'd0, 0, 0, 0, "p3.reset");
        runPrescaleCase(100, 99, 4'd0, "p3.nogap");
        runPrescaleCase(5, 8, 4'd2, "p3.gap");

        @(posedge clk);
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/upcount_ctrl.md
Name: upcount_ctrl

Overview:
- Sequencing controller for the team's 4-bit up counter datapath.
- Accepts a start command with a load value, a terminal value and a reload mode, then drives a registered counter from load to terminal at a prescaled rate.
- Reports busy, a terminal-count done pulse and a wrap pulse.
- Sits between a host/control FSM and any logic that consumes count_out.

Parameters:
- WIDTH, 4: counter width in bits; all arithmetic is modulo 2^WIDTH.
- PRESCALE, 1: number of enabled RUN cycles per counter advance; legal range 1..255.

Ports:
- clk  input  1  single system clock; everything is updated on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- stop  input  1  abort strobe; sampled in LOAD and RUN.
- load_val  input  WIDTH  start value, captured when start is accepted.
- term_val  input  WIDTH  terminal value, captured when start is accepted.
- auto_reload  input  1  1 = reload load value at terminal and keep running; 0 = one-shot. Captured when start is accepted.
- step_en  input  1  advance enable; when low, the prescaler and the counter freeze.
- count_out  output  WIDTH  registered counter value.
- busy  output  1  high while in LOAD or RUN.
- done  output  1  one-cycle pulse on each terminal event.
- wrap  output  1  one-cycle pulse when count_out rolls over from 2^WIDTH-1 to 0.

Behaviour:
- Clocking and reset:
  - One clock domain; reset is synchronous and active-high. Ports are named clk and reset.
  - reset (any state, mid-run included): next edge gives state=IDLE, count_out=0, busy=0, done=0, wrap=0, prescaler=0, captured registers=0.
- State encoding: IDLE, LOAD, RUN.
- IDLE:
  - busy=0; count_out holds its last value.
  - start=1 captures load_val, term_val and auto_reload into load_r, term_r and rl_r, then moves to LOAD.
  - stop is ignored in IDLE.
- LOAD (exactly one cycle):
  - count_out <= load_r; prescaler <= 0; moves to RUN.
  - stop=1 here goes to IDLE without loading.
- RUN:
  - The prescaler increments only on cycles with step_en=1.
  - A tick occurs on a cycle where step_en=1 and prescaler==PRESCALE-1; the prescaler then returns to 0.
  - On a tick with count_out != term_r: count_out <= count_out+1, truncated to WIDTH. wrap=1 on the next cycle if the old value was all-ones.
  - On a tick with count_out == term_r (terminal event): done=1 on the next cycle.
    - rl_r=1: count_out <= load_r and the block stays in RUN.
    - rl_r=0: count_out holds term_r, state -> IDLE, busy falls on the same edge.
  - start is ignored in RUN; reconfiguring requires stop.
- stop in RUN: state -> IDLE at the next edge; count_out holds; no done or wrap. stop takes priority over a same-cycle terminal event or wrap.
- done and wrap are registered and last exactly one cycle.
- Boundary cases:
  - load_val==term_val: the first tick is a terminal event.
  - term_val<load_val: the count wraps through 0, with wrap pulsed, before terminating.
- Latency:
  - Start sampled at edge E0 → LOAD; count_out=load_val after E1.
  - Ticks occur at E(1+k·PRESCALE), k≥1, while step_en is held high.
  - With d=(term-load) mod 2^WIDTH, done is high after edge E(1+(d+1)·PRESCALE).
  - busy is high after E0 through the terminal edge.
- step_en low pauses RUN indefinitely with no state change. It also stretches the latency above by one cycle per low cycle.

Test Plan:
- Reset then idle: reset=1 for 20 cycles, release → count_out=0, busy=0, done=0, wrap=0; start held low keeps everything static.
- One-shot, PRESCALE=1: load=3, term=7, auto_reload=0, step_en=1, start pulse at E0 → count_out 3,4,5,6,7 after E1..E5; done=1 and busy=0 after E6; count_out stays 7.
- Wrap path: load=14, term=1, one-shot → 14,15,0,1; wrap=1 the cycle after 15→0; done after E5; no second wrap.
- Auto-reload: load=2, term=4, auto_reload=1 → 2,3,4,2,3,4…; done pulses every 3 ticks; busy stays 1 until stop; stop at count 3 → IDLE next edge, count_out=3, no done.
- PRESCALE=3 with step_en gaps: load=0, term=2; drop step_en for 4 cycles mid-run → each count held for 3 enabled cycles; done delayed by exactly 4 cycles versus the no-gap run.
- Corner events: stop on the same cycle as the terminal tick → no done, IDLE. reset mid-RUN → all outputs 0 next edge. start during RUN → ignored, count sequence unchanged. load==term → done after E2 (PRESCALE=1).
